lv_scan_reg_bist_rsp: RTL and testbench

LV_SCAN_REG_BIST_RSP -- requirements
Module: lv_scan_reg_bist_rsp

---
 rtl/lv_scan_reg_bist_rsp_pkg.sv | 28 ++
 rtl/lv_scan_reg_bist.sv | 139 +++++++++++++
 tb/tb_lv_scan_reg_bist_rsp.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lv_scan_reg_bist_rsp_pkg.sv
// ---------------------------------------------------------------------------
// lv_param -- shared constants and types for the scan-register BIST responder.
//
// Contents:
//   LV_SCAN_REG_NUM : default number of scan registers checked per BIST run
//   bist_state_e    : responder FSM state encoding
//   PAR_ODD         : parity kind of the register-file read word (odd parity)
//   par_err()       : returns 1 when a 9-bit {parity, data} word breaks PAR_ODD
// ---------------------------------------------------------------------------
package lv_param;

    localparam int LV_SCAN_REG_NUM = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_ACK     = 2'd3
    } bist_state_e;

    // 1: the nine bits {parity, data} must contain an odd number of ones.
    localparam bit PAR_ODD = 1'b1;

    function automatic logic par_err(input logic [8:0] word);
        return (^word) != PAR_ODD;
    endfunction

endpackage

// File: rtl/lv_scan_reg_bist.sv
// ---------------------------------------------------------------------------
// lv_scan_reg_bist_rsp -- answers BIST scan-register check requests.
//
// Each request reads the next scan register (reg_idx) from the register file,
// checks its odd parity and returns a one-cycle ack with the error flag.
// A missing read response times out after RD_TMO_TH wait cycles and reports
// an error. Once all LV_SCAN_REG_NUM registers are done, further requests are
// acked immediately with an error and no read.
//
// Ports:
//   i_clk                : clock, rising edge
//   i_rst                : asynchronous active-high reset
//   i_bist_en            : BIST window; low aborts and clears the run
//   i_bist_scan_reg_req  : level request, held until ack
//   o_scan_reg_bist_ack  : one-cycle completion pulse
//   o_scan_reg_bist_err  : check result, qualified by ack (0 otherwise)
//   o_reg_rd_en          : one-cycle read strobe to the register file
//   o_reg_rd_addr        : register index being read
//   i_reg_rd_vld         : read data valid
//   i_reg_rd_data        : {parity, data[7:0]}
// ---------------------------------------------------------------------------
module lv_scan_reg_bist_rsp #(
    parameter int LV_SCAN_REG_NUM = lv_param::LV_SCAN_REG_NUM,
    parameter int REG_ADDR_W      = $clog2(LV_SCAN_REG_NUM),
    parameter int RD_TMO_TH       = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_bist_en,
    input  logic                  i_bist_scan_reg_req,
    output logic                  o_scan_reg_bist_ack,
    output logic                  o_scan_reg_bist_err,
    output logic                  o_reg_rd_en,
    output logic [REG_ADDR_W-1:0] o_reg_rd_addr,
    input  logic                  i_reg_rd_vld,
    input  logic [8:0]            i_reg_rd_data
);
    import lv_param::*;

    // reg_idx must be able to hold LV_SCAN_REG_NUM itself (the "all done" value).
    localparam int IDX_W = $clog2(LV_SCAN_REG_NUM + 1);
    localparam int CNT_W = (RD_TMO_TH > 1) ? $clog2(RD_TMO_TH) : 1;

    localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(LV_SCAN_REG_NUM);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RD_TMO_TH - 1);

    bist_state_e           r_state;
    logic [IDX_W-1:0]      r_reg_idx;
    logic [CNT_W-1:0]      r_tmo_cnt;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_rd_en;
    logic [REG_ADDR_W-1:0] r_rd_addr;

    logic                  w_par_err;

    assign w_par_err = par_err(i_reg_rd_data);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_reg_idx <= '0;
            r_tmo_cnt <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else if (!i_bist_en) begin
            // Closing the BIST window drops any transaction in flight silently.
            r_state   <= ST_IDLE;
            r_reg_idx <= '0;
            r_tmo_cnt <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            // Strobes are single-cycle; err is only meaningful alongside ack,
            // so it is cleared together with it.
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rd_en <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_bist_scan_reg_req) begin
                        if (r_reg_idx == IDX_DONE) begin
                            // Every register already checked: answer at once.
                            r_state <= ST_ACK;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state   <= ST_RD_REQ;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= REG_ADDR_W'(r_reg_idx);
                        end
                    end
                end

                ST_RD_REQ: begin
                    r_state   <= ST_RD_WAIT;
                    r_tmo_cnt <= '0;
                end

                ST_RD_WAIT: begin
                    // Valid data wins over a timeout landing in the same cycle.
                    if (i_reg_rd_vld) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        r_err   <= w_par_err;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                    end
                end

                ST_ACK: begin
                    r_state <= ST_IDLE;
                    if (r_reg_idx != IDX_DONE) begin
                        r_reg_idx <= r_reg_idx + IDX_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_scan_reg_bist_ack = r_ack;
    assign o_scan_reg_bist_err = r_err;
    assign o_reg_rd_en         = r_rd_en;
    assign o_reg_rd_addr       = r_rd_addr;

endmodule

// File: tb/tb_lv_scan_reg_bist_rsp.sv
// ---------------------------------------------------------------------------
// tb_lv_scan_reg_bist_rsp -- directed bench for lv_scan_reg_bist_rsp.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lv_scan_reg_bist_rsp;

    logic       clk;
    logic       rst;
    logic       bist_en;
    logic       req;
    logic       ack;
    logic       err;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic       rd_vld;
    logic [8:0] rd_data;

    int checks = 0;
    int errors = 0;

    lv_scan_reg_bist_rsp #(
        .LV_SCAN_REG_NUM(16),
        .REG_ADDR_W     (4),
        .RD_TMO_TH      (16)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_bist_en          (bist_en),
        .i_bist_scan_reg_req(req),
        .o_scan_reg_bist_ack(ack),
        .o_scan_reg_bist_err(err),
        .o_reg_rd_en        (rd_en),
        .o_reg_rd_addr      (rd_addr),
        .i_reg_rd_vld       (rd_vld),
        .i_reg_rd_data      (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One request/ack round. vld_off: samples after the rd_en sample at which
    // vld is pulsed for one cycle (0 = never). exp_lat counts samples from
    // raising req to seeing ack.
    task automatic run_txn(input string tag, input logic [8:0] data, input int vld_off,
                           input bit exp_rd, input logic [3:0] exp_addr,
                           input bit exp_err, input int exp_lat);
        int         cyc      = 0;
        int         rd_cyc   = -1;
        int         ack_cyc  = -1;
        int         rd_cnt   = 0;
        logic [3:0] addr_seen = '0;
        logic       err_seen  = 1'b0;
        req = 1'b1;
        while (ack_cyc < 0 && cyc < 40) begin
            step();
            cyc++;
            rd_vld = 1'b0;
            chk({tag, "_err_wo_ack"}, {31'd0, err & ~ack}, 32'd0);
            if (rd_en) begin
                rd_cnt++;
                rd_cyc    = cyc;
                addr_seen = rd_addr;
            end
            if (ack) begin
                ack_cyc  = cyc;
                err_seen = err;
                req      = 1'b0;
            end
            if (rd_cyc > 0 && vld_off > 0 && cyc == rd_cyc + vld_off && ack_cyc < 0) begin
                rd_vld  = 1'b1;
                rd_data = data;
            end
        end
        req    = 1'b0;
        rd_vld = 1'b0;
        chk({tag, "_lat"},    ack_cyc, exp_lat);
        chk({tag, "_err"},    {31'd0, err_seen}, {31'd0, exp_err});
        chk({tag, "_rd_cnt"}, rd_cnt, exp_rd ? 32'd1 : 32'd0);
        if (exp_rd) chk({tag, "_addr"}, {28'd0, addr_seen}, {28'd0, exp_addr});
        // ack lasts one cycle only; req stays low here for at least one cycle
        step();
        chk({tag, "_ack_1cyc"}, {31'd0, ack}, 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        bist_en = 1'b0;
        req     = 1'b0;
        rd_vld  = 1'b0;
        rd_data = 9'h000;

        @(negedge clk);
        chk("rst_ack",   {31'd0, ack},   32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_addr",  {28'd0, rd_addr}, 32'd0);
        rst     = 1'b0;
        bist_en = 1'b1;
        step();

        // 16 rounds; 9'h001 has odd total parity, 9'h003 (register 5) even.
        for (int i = 0; i < 16; i++) begin
            run_txn($sformatf("rd%0d", i), (i == 5) ? 9'h003 : 9'h001, 1,
                    1'b1, 4'(i), (i == 5), 3);
        end

        // All registers done: immediate error ack, no read.
        run_txn("done_skip", 9'h001, 1, 1'b0, 4'd0, 1'b1, 1);
        run_txn("done_skip2", 9'h001, 1, 1'b0, 4'd0, 1'b1, 1);

        // Close and reopen the window to restart from register 0.
        bist_en = 1'b0;
        step();
        chk("en_low_addr", {28'd0, rd_addr}, 32'd0);
        bist_en = 1'b1;
        step();

        // No vld: ack 17 cycles after rd_en (18 samples after req) with err.
        run_txn("timeout", 9'h001, 0, 1'b1, 4'd0, 1'b1, 18);
        // Late vld while idle must be ignored.
        rd_vld  = 1'b1;
        rd_data = 9'h003;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("late_vld_ack",   {31'd0, ack},   32'd0);
            chk("late_vld_rd_en", {31'd0, rd_en}, 32'd0);
        end
        rd_vld = 1'b0;
        step();

        // vld on the very cycle the timeout fires: data check wins (good data).
        run_txn("vld_at_tmo", 9'h001, 16, 1'b1, 4'd1, 1'b0, 18);
        // Same, with bad data: error comes from the parity check.
        run_txn("vld_at_tmo_bad", 9'h003, 16, 1'b1, 4'd2, 1'b1, 18);
        run_txn("rd3", 9'h001, 1, 1'b1, 4'd3, 1'b0, 3);

        // Drop the window in RD_WAIT while vld arrives: no ack, restart at 0.
        req = 1'b1;
        step();
        chk("abort_rd_en", {31'd0, rd_en}, 32'd1);
        chk("abort_addr",  {28'd0, rd_addr}, 32'd4);
        step();
        bist_en = 1'b0;
        req     = 1'b0;
        rd_vld  = 1'b1;
        rd_data = 9'h001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_ack", {31'd0, ack}, 32'd0);
            rd_vld = 1'b0;
        end
        bist_en = 1'b1;
        step();
        run_txn("after_abort", 9'h001, 1, 1'b1, 4'd0, 1'b0, 3);
        run_txn("after_abort1", 9'h001, 1, 1'b1, 4'd1, 1'b0, 3);

        // Reset pulse in RD_WAIT: outputs clear without waiting for a clock.
        req = 1'b1;
        step();
        step();
        chk("pre_rst_addr", {28'd0, rd_addr}, 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_addr", {28'd0, rd_addr}, 32'd0);
        chk("async_rst_ack",  {31'd0, ack},     32'd0);
        chk("async_rst_err",  {31'd0, err},     32'd0);
        chk("async_rst_rd_en",{31'd0, rd_en},   32'd0);
        req    = 1'b0;
        rd_vld = 1'b1;
        rd_data = 9'h001;
        @(negedge clk);
        rst    = 1'b0;
        rd_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_ack", {31'd0, ack}, 32'd0);
        end
        run_txn("after_rst", 9'h001, 1, 1'b1, 4'd0, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
